// File: rtl/pmem_if.sv
// Block-memory request/response bus between the cache arbiter (master)
// and the physical-memory responder (slave).
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         protocol_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, protocol_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, protocol_err
  );
endinterface

// File: rtl/pmem_responder.sv
// Physical-memory responder: whole-block reads/writes with a fixed
// programmable latency and a one-cycle pmem_resp pulse.
module pmem_responder #(
  parameter int IDX_BITS = 6,
  parameter int LATENCY  = 4    // 1..15
) (
  input  logic  clk,
  input  logic  reset,
  pmem_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_REC  = 2'd3;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam int         DEPTH  = 1 << IDX_BITS;

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [127:0]        wdata_q, wdata_d;
  logic                resp_q, resp_d;
  logic [127:0]        rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [127:0]        mem [DEPTH];

  logic req;
  assign req = bus.pmem_read | bus.pmem_write;

  // Offset bits and aliasing upper bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pmem_address[15:IDX_BITS+4], bus.pmem_address[3:0]};

  // Next-state: capture in IDLE, count down in BUSY, respond, then one dead cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Read+write together is served as a write and flagged.
          wr_d    = bus.pmem_write;
          idx_d   = bus.pmem_address[IDX_BITS+3:4];
          wdata_d = bus.pmem_wdata;
          err_d   = err_q | (bus.pmem_read & bus.pmem_write);
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req) begin
          // Requester gave up: drop silently, nothing committed.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_d = 1'b1;
        if (!wr_q) rdata_d = mem[idx_q];
        state_d = S_REC;
      end
      default: begin
        // Requests are ignored here so a registered requester that drops
        // one cycle after pmem_resp is not served twice.
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; array is left out of reset on purpose.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write commit on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wr_q) mem[idx_q] <= wdata_q;
  end

  assign bus.pmem_resp    = resp_q;
  assign bus.pmem_rdata   = rdata_q;
  assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder with a response scoreboard and block model.
module tb_pmem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  pmem_if bus ();

  pmem_responder #(.IDX_BITS(6), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] model [64];
  logic [127:0] last_rdata;
  logic [127:0] sb_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [15:0] a);
    return int'(a[9:4]);
  endfunction

  // Full request: drive, expect resp exactly LAT edges after acceptance,
  // optionally hold the request 'hold' cycles past the resp.
  task automatic req(input bit rd, input bit wr, input logic [15:0] a,
                     input logic [127:0] wd, input int hold, input string tag);
    logic [127:0] exp;
    @(negedge clk);
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = a;
    bus.pmem_wdata   = wd;
    if (wr) begin
      model[idx(a)] = wd;
      sb_q.push_back(last_rdata);
    end else begin
      last_rdata = model[idx(a)];
      sb_q.push_back(last_rdata);
    end
    @(posedge clk); #1;
    check({tag, "_resp_c0"}, {127'd0, bus.pmem_resp}, 128'd0);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c < LAT) begin
        check($sformatf("%s_resp_c%0d", tag, c), {127'd0, bus.pmem_resp}, 128'd0);
      end else begin
        check({tag, "_resp"}, {127'd0, bus.pmem_resp}, 128'd1);
        exp = sb_q.pop_front();
        check({tag, "_rdata"}, bus.pmem_rdata, exp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_noresp"}, {127'd0, bus.pmem_resp}, 128'd0);
    end
    @(negedge clk);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    @(posedge clk); #1;
    check({tag, "_after_noresp"}, {127'd0, bus.pmem_resp}, 128'd0);
  endtask

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hFEEDFACE_CAFEBABE_11223344_55667788;
  localparam logic [127:0] D3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] DA = {8{16'hAAAA}};
  localparam logic [127:0] D4 = 128'h00000000_00000000_DEADBEEF_00000100;

  initial begin
    for (int i = 0; i < 64; i++) model[i] = '0;
    last_rdata       = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    reset = 1'b1;
    #1;
    check("rst_resp",  {127'd0, bus.pmem_resp}, 128'd0);
    check("rst_rdata", bus.pmem_rdata, 128'd0);
    check("rst_err",   {127'd0, bus.protocol_err}, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: write then read back
    req(1'b0, 1'b1, 16'h0040, D1, 0, "t1_wr");
    req(1'b1, 1'b0, 16'h0040, '0, 0, "t1_rd");

    // 2: offset bits ignored, upper bits alias
    req(1'b0, 1'b1, 16'h0050, D2, 0, "t2_wr");
    req(1'b1, 1'b0, 16'h0450, '0, 0, "t2_rd_alias");
    req(1'b1, 1'b0, 16'h005E, '0, 0, "t2_rd_off");

    // 3: request held past resp gives one pulse; next read accepted normally
    req(1'b1, 1'b0, 16'h0040, '0, 1, "t3_hold");
    req(1'b1, 1'b0, 16'h0050, '0, 0, "t3_next");

    // 4: abort mid-BUSY commits nothing
    req(1'b0, 1'b1, 16'h0080, D3, 0, "t4_init");
    @(negedge clk);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 16'h0080;
    bus.pmem_wdata   = DA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.pmem_write = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      check("t4_abort_noresp", {127'd0, bus.pmem_resp}, 128'd0);
    end
    req(1'b1, 1'b0, 16'h0080, '0, 0, "t4_rd");

    // 5: read+write together acts as write and sets sticky error
    req(1'b1, 1'b1, 16'h00C0, DA, 0, "t5_both");
    check("t5_err", {127'd0, bus.protocol_err}, 128'd1);
    req(1'b1, 1'b0, 16'h00C0, '0, 0, "t5_rd");
    check("t5_err_sticky", {127'd0, bus.protocol_err}, 128'd1);

    // 6: async reset in BUSY drops an uncommitted write
    req(1'b0, 1'b1, 16'h0100, D4, 0, "t6_init");
    @(negedge clk);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 16'h0100;
    bus.pmem_wdata   = D1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_resp",  {127'd0, bus.pmem_resp}, 128'd0);
    check("t6_rst_err",   {127'd0, bus.protocol_err}, 128'd0);
    check("t6_rst_rdata", bus.pmem_rdata, 128'd0);
    last_rdata = '0;
    @(negedge clk);
    bus.pmem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req(1'b1, 1'b0, 16'h0100, '0, 0, "t6_rd");
    check("t6_sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net in case a wait ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable physical-memory responder for the pipeline's cache subsystem.
- Sits on the memory side of the cache arbiter and serves its pmem_read / pmem_write requests.
- Requests are whole 128-bit blocks (lc3b_block), held in an internal block array.
- Each request gets a fixed, programmable response latency and a one-cycle pmem_resp pulse.

Parameters:
- IDX_BITS, 6: log2 of the number of blocks stored (64 blocks = 1 KiB).
- LATENCY, 4: cycles from request acceptance to pmem_resp; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pmem_read  input  1  block read request; held high until pmem_resp.
- pmem_write  input  1  block write request; held high until pmem_resp.
- pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored.
- pmem_wdata  input  128  write block (lc3b_block).
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_rdata  output  128  read block; valid in the pmem_resp cycle.
- protocol_err  output  1  sticky flag; set on a simultaneous read+write request.

Behaviour:
- Reset values (async assert): pmem_resp=0, pmem_rdata=0, protocol_err=0, state=IDLE, latency counter=0. Array contents are not affected by reset.
- Indexing: block index = pmem_address[IDX_BITS+3:4]. Address bits above the index alias.
- IDLE state:
  - On (pmem_read | pmem_write), capture the command, index and wdata; load counter = LATENCY-1; go to BUSY.
  - If read and write are both high, treat the request as a write and set protocol_err.
- BUSY state:
  - Decrement the counter each cycle.
  - Inputs are ignored after capture; address or wdata changes have no effect.
  - If both request lines drop before the counter reaches 0: abort to IDLE, no pmem_resp, no array write.
  - When the counter is 0 and the request is still present: go to RESP.
- RESP state (one cycle):
  - pmem_resp=1.
  - Read: pmem_rdata = array[index].
  - Write: array[index] <= captured wdata, committed this edge. pmem_rdata is unchanged.
  - Go to RECOVER.
- RECOVER state (one cycle):
  - Request lines are ignored, so a requester whose request deasserts one cycle after pmem_resp (registered arbiter) is not served twice.
  - Go to IDLE.
- Timing: request first high at edge N (sampled in IDLE) gives pmem_resp high during cycle N+LATENCY. Back-to-back throughput is one request per LATENCY+2 cycles.
- Outputs:
  - pmem_resp and pmem_rdata are registered.
  - pmem_rdata holds its last read value between responses.
  - protocol_err clears only on reset.
- Reset mid-operation: the pending request is dropped, no pmem_resp, and an uncommitted write is lost. The array keeps its prior contents.
- LATENCY=1 is legal: IDLE to RESP directly, and the counter stays 0.

Test Plan:
1. Reset, then write address 0x0040 with wdata 0x0123…CDEF. Expect pmem_resp exactly LATENCY=4 cycles after the request, for 1 cycle. Then read 0x0040 and expect pmem_rdata = 0x0123…CDEF in the resp cycle.
2. Alias and offset: write 0x0050, then read 0x0450 and 0x005E (IDX_BITS=6). Both reads must return the written block.
3. Request held one cycle past pmem_resp (registered requester): exactly one pmem_resp pulse. A new read issued 2 cycles after the resp is accepted and responds LATENCY cycles later.
4. Abort: a write to 0x0080 drops after 2 cycles. Expect no pmem_resp, and a later read of 0x0080 returns the old contents.
5. Read and write both high on 0x00C0 with wdata 0xAAAA…: behaves as a write, protocol_err=1 and stays 1. A later read returns 0xAAAA….
6. Assert reset in BUSY during a write to 0x0100: pmem_resp and protocol_err go to 0 immediately (async), and a later read of 0x0100 returns the pre-write data.
